instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 45 ++++
 rtl/instr_encoder_imm_field_pack.sv | 61 ++++++
 rtl/instr_encoder.sv | 127 ++++++++++++
 tb/tb_instr_encoder.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: format codes, the NOP word,
// immediate range limits and the request bundle carried through stage 1.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    SRC_ILL0   = 3'b000,
    SRC_I      = 3'b001,
    SRC_S      = 3'b010,
    SRC_B      = 3'b011,
    SRC_U      = 3'b100,
    SRC_J      = 3'b101,
    SRC_ISHIFT = 3'b110,
    SRC_ILL7   = 3'b111
  } src_ext_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Lowest bit that must equal the sign for each signed format, plus the
  // U-type zero field and the shift-amount width.
  localparam int IMM_I_SIGN_BIT = 11;
  localparam int IMM_B_SIGN_BIT = 12;
  localparam int IMM_J_SIGN_BIT = 20;
  localparam int IMM_U_LOW_BITS = 12;
  localparam int SHAMT_BITS     = 5;

  typedef struct packed {
    src_ext_e    srcExt;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } enc_req_t;

  // True when imm[31:signBit] are all copies of one bit, i.e. the value fits
  // a signed field whose sign sits at signBit.
  function automatic logic sign_ext_ok(input logic [31:0] imm, input int signBit);
    logic [31:0] upper;
    upper = 32'($signed(imm) >>> signBit);
    return (upper == '0) || (upper == '1);
  endfunction

endpackage

// File: rtl/instr_encoder_imm_field_pack.sv
// Combinational immediate packer: scatters ImmIn into the instruction word for
// the selected format and flags values the format cannot represent.
module imm_field_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  SrcExt,
  input  logic [31:0] ImmIn,
  input  logic [6:0]  Opcode,
  input  logic [2:0]  Funct3,
  input  logic [6:0]  Funct7,
  input  logic [4:0]  Rd,
  input  logic [4:0]  Rs1,
  input  logic [4:0]  Rs2,
  output logic [31:0] Instr,
  output logic        RangeErr
);

  logic [31:0] packedWord;
  logic        legal;

  always_comb begin
    packedWord = '0;
    legal      = 1'b0;
    case (src_ext_e'(SrcExt))
      SRC_I: begin
        packedWord = {ImmIn[11:0], Rs1, Funct3, Rd, Opcode};
        legal      = sign_ext_ok(ImmIn, IMM_I_SIGN_BIT);
      end
      SRC_S: begin
        packedWord = {ImmIn[11:5], Rs2, Rs1, Funct3, ImmIn[4:0], Opcode};
        legal      = sign_ext_ok(ImmIn, IMM_I_SIGN_BIT);
      end
      SRC_B: begin
        packedWord = {ImmIn[12], ImmIn[10:5], Rs2, Rs1, Funct3, ImmIn[4:1], ImmIn[11], Opcode};
        legal      = sign_ext_ok(ImmIn, IMM_B_SIGN_BIT) && !ImmIn[0];
      end
      SRC_U: begin
        packedWord = {ImmIn[31:12], Rd, Opcode};
        legal      = (ImmIn[IMM_U_LOW_BITS-1:0] == '0);
      end
      SRC_J: begin
        packedWord = {ImmIn[20], ImmIn[10:1], ImmIn[11], ImmIn[19:12], Rd, Opcode};
        legal      = sign_ext_ok(ImmIn, IMM_J_SIGN_BIT) && !ImmIn[0];
      end
      SRC_ISHIFT: begin
        packedWord = {Funct7, ImmIn[SHAMT_BITS-1:0], Rs1, Funct3, Rd, Opcode};
        legal      = (ImmIn[31:SHAMT_BITS] == '0);
      end
      default: begin
        packedWord = '0;
        legal      = 1'b0;
      end
    endcase

    // Errored requests still produce a harmless word so the consumer never
    // sees a half-encoded instruction.
    RangeErr = !legal;
    Instr    = legal ? packedWord : NOP_INSTR;
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage instruction encoder: stage 1 holds the request, stage 2 holds the
// packed word, with valid/ready handshakes and saturating output counters.
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        InValid,
  output logic        InReady,
  input  logic [2:0]  SrcExt,
  input  logic [31:0] ImmIn,
  input  logic [6:0]  Opcode,
  input  logic [2:0]  Funct3,
  input  logic [6:0]  Funct7,
  input  logic [4:0]  Rd,
  input  logic [4:0]  Rs1,
  input  logic [4:0]  Rs2,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] Instr,
  output logic        RangeErr,
  output logic [7:0]  ErrCount,
  output logic [15:0] EncCount
);

  logic        s1Valid_q, s1Valid_d;
  enc_req_t    s1Req_q, s1Req_d;
  logic        s2Valid_q, s2Valid_d;
  logic [31:0] instr_q, instr_d;
  logic        rangeErr_q, rangeErr_d;
  logic [15:0] encCount_q, encCount_d;
  logic [7:0]  errCount_q, errCount_d;

  logic        accept;
  logic        s2Load;
  logic        outFire;
  logic [31:0] packInstr;
  logic        packErr;

  // Stage 2 frees up in the same cycle it is drained, which is what lets the
  // pipe sustain one request per cycle under a ready consumer.
  assign s2Load  = s1Valid_q && (!s2Valid_q || OutReady);
  assign InReady = !s1Valid_q || s2Load;
  assign accept  = InValid && InReady;
  assign outFire = s2Valid_q && OutReady;

  imm_field_pack u_pack (
    .SrcExt   (s1Req_q.srcExt),
    .ImmIn    (s1Req_q.imm),
    .Opcode   (s1Req_q.opcode),
    .Funct3   (s1Req_q.funct3),
    .Funct7   (s1Req_q.funct7),
    .Rd       (s1Req_q.rd),
    .Rs1      (s1Req_q.rs1),
    .Rs2      (s1Req_q.rs2),
    .Instr    (packInstr),
    .RangeErr (packErr)
  );

  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1Req_d    = s1Req_q;
    s2Valid_d  = s2Valid_q;
    instr_d    = instr_q;
    rangeErr_d = rangeErr_q;
    encCount_d = encCount_q;
    errCount_d = errCount_q;

    if (accept) begin
      s1Valid_d      = 1'b1;
      s1Req_d.srcExt = src_ext_e'(SrcExt);
      s1Req_d.imm    = ImmIn;
      s1Req_d.opcode = Opcode;
      s1Req_d.funct3 = Funct3;
      s1Req_d.funct7 = Funct7;
      s1Req_d.rd     = Rd;
      s1Req_d.rs1    = Rs1;
      s1Req_d.rs2    = Rs2;
    end else if (s2Load) begin
      s1Valid_d = 1'b0;
    end

    if (s2Load) begin
      s2Valid_d  = 1'b1;
      instr_d    = packInstr;
      rangeErr_d = packErr;
    end else if (outFire) begin
      s2Valid_d = 1'b0;
    end

    if (outFire) begin
      if (encCount_q != 16'hFFFF) begin
        encCount_d = encCount_q + 16'd1;
      end
      if (rangeErr_q && (errCount_q != 8'hFF)) begin
        errCount_d = errCount_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q  <= 1'b0;
      s1Req_q    <= '0;
      s2Valid_q  <= 1'b0;
      instr_q    <= '0;
      rangeErr_q <= 1'b0;
      encCount_q <= '0;
      errCount_q <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Req_q    <= s1Req_d;
      s2Valid_q  <= s2Valid_d;
      instr_q    <= instr_d;
      rangeErr_q <= rangeErr_d;
      encCount_q <= encCount_d;
      errCount_q <= errCount_d;
    end
  end

  assign OutValid = s2Valid_q;
  assign Instr    = instr_q;
  assign RangeErr = rangeErr_q;
  assign EncCount = encCount_q;
  assign ErrCount = errCount_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: a queue-based reference model predicts every
// output word and the counters, driven by directed and random requests.
module tb_instr_encoder;

  typedef struct {
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } reqT;

  logic        clk;
  logic        rst_n;
  logic        InValid;
  logic        InReady;
  logic [2:0]  SrcExt;
  logic [31:0] ImmIn;
  logic [6:0]  Opcode;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic [4:0]  Rd;
  logic [4:0]  Rs1;
  logic [4:0]  Rs2;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] Instr;
  logic        RangeErr;
  logic [7:0]  ErrCount;
  logic [15:0] EncCount;

  int testCount = 0;
  int failCount = 0;

  reqT expQ[$];
  int  modelEnc = 0;
  int  modelErr = 0;

  instr_encoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .InValid  (InValid),
    .InReady  (InReady),
    .SrcExt   (SrcExt),
    .ImmIn    (ImmIn),
    .Opcode   (Opcode),
    .Funct3   (Funct3),
    .Funct7   (Funct7),
    .Rd       (Rd),
    .Rs1      (Rs1),
    .Rs2      (Rs2),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Instr    (Instr),
    .RangeErr (RangeErr),
    .ErrCount (ErrCount),
    .EncCount (EncCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference encoder: range from signed value limits, placement by shifts.
  function automatic logic [32:0] modelEncode(input reqT r);
    logic [31:0] imm, op, rd, f3, rs1, rs2, f7, w;
    longint      s;
    bit          ok;
    imm = r.imm;
    op  = 32'(r.opcode);
    rd  = 32'(r.rd);
    f3  = 32'(r.funct3);
    rs1 = 32'(r.rs1);
    rs2 = 32'(r.rs2);
    f7  = 32'(r.funct7);
    s   = longint'($signed(imm));
    ok  = 1'b0;
    w   = '0;
    case (r.fmt)
      3'd1: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      3'd2: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
           | ((imm & 32'h1F) << 7) | op;
      end
      3'd3: begin
        ok = (s >= -4096) && (s <= 4095) && ((s % 2) == 0);
        w  = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
           | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
           | (((imm >> 11) & 32'h1) << 7) | op;
      end
      3'd4: begin
        ok = (imm % 4096) == 0;
        w  = (imm & 32'hFFFF_F000) | (rd << 7) | op;
      end
      3'd5: begin
        ok = (s >= -1048576) && (s <= 1048575) && ((s % 2) == 0);
        w  = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
           | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
      end
      3'd6: begin
        ok = imm < 32;
        w  = (f7 << 25) | (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      default: ok = 1'b0;
    endcase
    return ok ? {1'b0, w} : {1'b1, 32'h0000_0013};
  endfunction

  // Standard immediate-extension decode of an encoded word.
  function automatic logic [31:0] decodeImm(input logic [2:0] fmt, input logic [31:0] w);
    logic [31:0] s;
    s = {32{w[31]}};
    case (fmt)
      3'd1:    return {s[31:12], w[31:20]};
      3'd2:    return {s[31:12], w[31:25], w[11:7]};
      3'd3:    return {s[31:13], w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd4:    return {w[31:12], 12'b0};
      3'd5:    return {s[31:21], w[31], w[19:12], w[20], w[30:21], 1'b0};
      3'd6:    return {27'b0, w[24:20]};
      default: return '0;
    endcase
  endfunction

  function automatic reqT mkReq(input logic [2:0] fmt, input logic [31:0] imm, input logic [6:0] op,
                                input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2);
    reqT r;
    r.fmt = fmt; r.imm = imm; r.opcode = op; r.funct3 = f3; r.funct7 = 7'h00;
    r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    return r;
  endfunction

  function automatic reqT randFields();
    reqT r;
    r.fmt    = 3'($urandom_range(0, 7));
    r.imm    = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 8191)) - 32'd4096;
    r.opcode = 7'($urandom());
    r.funct3 = 3'($urandom());
    r.funct7 = 7'($urandom());
    r.rd     = 5'($urandom());
    r.rs1    = 5'($urandom());
    r.rs2    = 5'($urandom());
    return r;
  endfunction

  function automatic reqT randLegal();
    reqT r;
    int  v;
    r     = randFields();
    r.fmt = 3'($urandom_range(1, 6));
    case (r.fmt)
      3'd1, 3'd2: begin v = int'($urandom_range(0, 4095)) - 2048; r.imm = 32'(v); end
      3'd3:       begin v = int'($urandom_range(0, 4095)) * 2 - 4096; r.imm = 32'(v); end
      3'd4:       r.imm = $urandom() & 32'hFFFF_F000;
      3'd5:       begin v = int'($urandom_range(0, 1048575)) * 2 - 1048576; r.imm = 32'(v); end
      default:    r.imm = 32'($urandom_range(0, 31));
    endcase
    return r;
  endfunction

  task automatic driveFields(input reqT r);
    SrcExt = r.fmt; ImmIn = r.imm; Opcode = r.opcode; Funct3 = r.funct3;
    Funct7 = r.funct7; Rd = r.rd; Rs1 = r.rs1; Rs2 = r.rs2;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Present one request until accepted; readyPct shapes consumer backpressure.
  task automatic applyStimulus(input reqT r, input int readyPct);
    bit done;
    done = 1'b0;
    driveFields(r);
    InValid = 1'b1;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (InReady) done = 1'b1;
      nextCycle();
      OutReady = ($urandom_range(0, 99) < readyPct);
    end
    InValid = 1'b0;
    driveFields(randFields());
    if (!done) checkOutput("acceptTimeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    OutReady = 1'b1;
    InValid  = 1'b0;
    for (int c = 0; c < 100 && expQ.size() != 0; c++) nextCycle();
    nextCycle();
    checkOutput("drainEmpty", 32'(expQ.size()), 32'd0);
  endtask

  // Scoreboard: counters, hold-while-stalled, ordering and round-trip decode.
  logic        prevStall = 1'b0;
  logic [31:0] prevInstr;
  logic        prevErr;
  always @(negedge clk) begin
    reqT         e;
    reqT         cur;
    logic [32:0] m;
    logic [31:0] wantImm;
    if (!rst_n) begin
      expQ.delete();
      modelEnc  = 0;
      modelErr  = 0;
      prevStall = 1'b0;
    end else begin
      checkOutput("encCount", 32'(EncCount), 32'(modelEnc));
      checkOutput("errCount", 32'(ErrCount), 32'(modelErr));
      if (prevStall) begin
        checkOutput("holdValid", 32'(OutValid), 32'd1);
        checkOutput("holdInstr", Instr, prevInstr);
        checkOutput("holdErr", 32'(RangeErr), 32'(prevErr));
      end
      if (OutValid && OutReady) begin
        if (expQ.size() == 0) begin
          checkOutput("spuriousOut", Instr, 32'hxxxx_xxxx);
        end else begin
          e = expQ.pop_front();
          m = modelEncode(e);
          checkOutput("instr", Instr, m[31:0]);
          checkOutput("rangeErr", 32'(RangeErr), 32'(m[32]));
          if (!m[32]) begin
            wantImm = (e.fmt == 3'd6) ? {27'b0, e.imm[4:0]} : e.imm;
            checkOutput("roundTrip", decodeImm(e.fmt, Instr), wantImm);
          end
          if (modelEnc < 65535) modelEnc++;
          if (RangeErr && modelErr < 255) modelErr++;
        end
      end
      if (InValid && InReady) begin
        cur.fmt = SrcExt; cur.imm = ImmIn; cur.opcode = Opcode; cur.funct3 = Funct3;
        cur.funct7 = Funct7; cur.rd = Rd; cur.rs1 = Rs1; cur.rs2 = Rs2;
        expQ.push_back(cur);
      end
      prevStall = OutValid && !OutReady;
      prevInstr = Instr;
      prevErr   = RangeErr;
    end
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation did not complete, failed=%0d", failCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reqT         a, b, c;
    logic [32:0] m;
    int          acc, idx;
    reqT         trio[3];

    rst_n = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    driveFields(mkReq(3'd0, 32'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0));
    #1;
    checkOutput("rstInReady", 32'(InReady), 32'd1);
    checkOutput("rstOutValid", 32'(OutValid), 32'd0);
    checkOutput("rstInstr", Instr, 32'd0);
    checkOutput("rstRangeErr", 32'(RangeErr), 32'd0);
    checkOutput("rstEncCount", 32'(EncCount), 32'd0);
    checkOutput("rstErrCount", 32'(ErrCount), 32'd0);

    // Hand-computed words pin the reference model itself.
    m = modelEncode(mkReq(3'd1, 32'hFFFF_FFFF, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0));
    checkOutput("modelI", m[31:0], 32'hFFF1_0093);
    m = modelEncode(mkReq(3'd2, 32'd8, 7'h23, 3'b010, 5'd0, 5'd2, 5'd5));
    checkOutput("modelS", m[31:0], 32'h0051_2423);
    m = modelEncode(mkReq(3'd1, 32'd2048, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0));
    checkOutput("modelIrange", {m[31:1], m[32]}, 32'h0000_0013);
    m = modelEncode(mkReq(3'd3, 32'd3, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2));
    checkOutput("modelBodd", 32'(m[32]), 32'd1);
    m = modelEncode(mkReq(3'd7, 32'd0, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0));
    checkOutput("modelIllegal", 32'(m[32]), 32'd1);

    nextCycle();
    nextCycle();
    rst_n = 1'b1;

    // Single I-type request: OutValid two edges after acceptance.
    driveFields(mkReq(3'd1, 32'hFFFF_FFFF, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0));
    InValid = 1'b1;
    @(negedge clk);
    checkOutput("firstAccept", 32'(InReady), 32'd1);
    nextCycle();
    InValid = 1'b0;
    checkOutput("lat1Valid", 32'(OutValid), 32'd0);
    nextCycle();
    checkOutput("lat2Valid", 32'(OutValid), 32'd1);
    checkOutput("lat2Instr", Instr, 32'hFFF1_0093);
    checkOutput("lat2Err", 32'(RangeErr), 32'd0);
    nextCycle();
    checkOutput("encAfterOne", 32'(EncCount), 32'd1);
    checkOutput("validDropped", 32'(OutValid), 32'd0);

    applyStimulus(mkReq(3'd2, 32'd8, 7'h23, 3'b010, 5'd0, 5'd2, 5'd5), 100);
    applyStimulus(mkReq(3'd1, 32'd2048, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0), 100);
    applyStimulus(mkReq(3'd3, 32'd3, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2), 100);
    applyStimulus(mkReq(3'd7, 32'd0, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0), 100);
    drain();
    checkOutput("encAfterDirected", 32'(EncCount), 32'd5);
    checkOutput("errAfterDirected", 32'(ErrCount), 32'd3);

    // Backpressure: only two requests fit while the consumer stalls.
    trio[0] = randLegal(); trio[1] = randLegal(); trio[2] = randLegal();
    OutReady = 1'b0;
    acc = 0; idx = 0;
    driveFields(trio[0]);
    InValid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (InReady) begin acc++; idx++; end
      nextCycle();
      if (idx < 3) driveFields(trio[idx]);
    end
    checkOutput("bpAccepted", 32'(acc), 32'd2);
    checkOutput("bpInReady", 32'(InReady), 32'd0);
    OutReady = 1'b1;
    @(negedge clk);
    checkOutput("bpOut0", 32'(OutValid), 32'd1);
    checkOutput("bpThirdAccept", 32'(InReady), 32'd1);
    nextCycle();
    InValid = 1'b0;
    @(negedge clk);
    checkOutput("bpOut1", 32'(OutValid), 32'd1);
    @(negedge clk);
    checkOutput("bpOut2", 32'(OutValid), 32'd1);
    drain();

    // Reset with both stages full discards everything in flight.
    a = randLegal(); b = randLegal(); c = randLegal();
    OutReady = 1'b0;
    driveFields(a); InValid = 1'b1;
    nextCycle();
    driveFields(b);
    nextCycle();
    InValid = 1'b0;
    checkOutput("fullValid", 32'(OutValid), 32'd1);
    checkOutput("fullInReady", 32'(InReady), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", 32'(OutValid), 32'd0);
    checkOutput("midRstEnc", 32'(EncCount), 32'd0);
    checkOutput("midRstErr", 32'(ErrCount), 32'd0);
    checkOutput("midRstInReady", 32'(InReady), 32'd1);
    nextCycle();
    OutReady = 1'b1;
    rst_n = 1'b1;
    driveFields(c); InValid = 1'b1;
    @(negedge clk);
    checkOutput("postRstAccept", 32'(InReady), 32'd1);
    nextCycle();
    InValid = 1'b0;
    drain();
    checkOutput("postRstEnc", 32'(EncCount), 32'd1);

    // Random legal traffic for the round-trip property, then mixed traffic.
    for (int n = 0; n < 10000; n++) begin
      applyStimulus(randLegal(), 75);
      if ($urandom_range(0, 4) == 0) begin
        driveFields(randFields());
        nextCycle();
        OutReady = ($urandom_range(0, 99) < 75);
      end
    end
    for (int n = 0; n < 1500; n++) applyStimulus(randFields(), 60);
    drain();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
